// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//   Program-counter control FSM. Every cycle it chooses between increment,
//   hold and load for the PC, and selects the load source. It handles
//   direct branches (target on OR2), register-indirect jumps (target in R0)
//   and returns whose target comes from data memory through a read
//   handshake. It also handles hazard stalls, halt, a DM timeout fault, and
//   the bubble cycles that follow every redirect.
//
//   The PC control outputs are decoded combinationally from the registered
//   state and the current inputs, so the PC register acts on the same edge.
//
// Parameters
//   FLUSH_CYCLES  number of cycles flush is held after a PC load (1..7)
//   DM_TIMEOUT    WAIT_DM cycles without dm_valid before FAULT (1..255)
//
// Ports
//   CLK        in   clock, all state updates on the rising edge
//   RST_N      in   synchronous reset, active-low
//   stall_in   in   hazard stall, hold PC this cycle
//   br_req     in   direct branch/jump decoded, target on OR2
//   br_taken   in   branch condition true (qualifies br_req)
//   jr_req     in   indirect jump, target in R0
//   ret_req    in   return, target read from data memory
//   dm_valid   in   data-memory read data valid on the DM bus
//   halt_in    in   HLT decoded, freeze PC until reset
//   I_PC       out  increment PC
//   L_PC       out  load PC from the selected source
//   S11, S10   out  source select: 11=R0, 10=DM, 01=OR2, 00=none
//   dm_rd_en   out  data-memory read request for the return address
//   flush      out  squash fetch/decode stage contents
//   halted     out  sequencer is in HALT
//   fault      out  DM handshake timed out (sticky until reset)
// -----------------------------------------------------------------------------
module pc_sequencer #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned DM_TIMEOUT   = 15
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic stall_in,
  input  logic br_req,
  input  logic br_taken,
  input  logic jr_req,
  input  logic ret_req,
  input  logic dm_valid,
  input  logic halt_in,
  output logic I_PC,
  output logic L_PC,
  output logic S11,
  output logic S10,
  output logic dm_rd_en,
  output logic flush,
  output logic halted,
  output logic fault
);

  typedef enum logic [2:0] {
    RESET_HOLD = 3'd0,
    RUN        = 3'd1,
    WAIT_DM    = 3'd2,
    FLUSH      = 3'd3,
    HALT       = 3'd4,
    FAULT      = 3'd5
  } state_t;

  localparam logic [2:0] FLUSH_LEN = 3'(FLUSH_CYCLES);
  localparam logic [7:0] TMO_LEN   = 8'(DM_TIMEOUT);

  state_t     state;
  state_t     state_next;
  logic [2:0] flush_cnt;
  logic [2:0] flush_cnt_next;
  logic [7:0] tmo_cnt;
  logic [7:0] tmo_cnt_next;

  // Counters stop at their maximum rather than wrapping back to zero.
  function automatic logic [2:0] sat_inc3(input logic [2:0] v);
    return (v == 3'd7) ? v : v + 3'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'h01;
  endfunction

  // State and counter registers
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state     <= RESET_HOLD;
      flush_cnt <= 3'd0;
      tmo_cnt   <= 8'd0;
    end else begin
      state     <= state_next;
      flush_cnt <= flush_cnt_next;
      tmo_cnt   <= tmo_cnt_next;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_next     = state;
    flush_cnt_next = flush_cnt;
    tmo_cnt_next   = tmo_cnt;
    I_PC           = 1'b0;
    L_PC           = 1'b0;
    S11            = 1'b0;
    S10            = 1'b0;
    dm_rd_en       = 1'b0;
    flush          = 1'b0;
    halted         = 1'b0;
    fault          = 1'b0;

    unique case (state)
      RESET_HOLD: begin
        flush_cnt_next = 3'd0;
        tmo_cnt_next   = 8'd0;
        state_next     = RUN;
      end

      RUN: begin
        // Fixed priority: halt > return > indirect jump > taken branch > stall.
        // An untaken branch is not a request and falls through.
        if (halt_in) begin
          state_next = HALT;
        end else if (ret_req) begin
          dm_rd_en     = 1'b1;
          S11          = 1'b1;
          tmo_cnt_next = 8'd0;
          if (dm_valid) begin
            L_PC           = 1'b1;
            flush_cnt_next = 3'd0;
            state_next     = FLUSH;
          end else begin
            state_next = WAIT_DM;
          end
        end else if (jr_req) begin
          L_PC           = 1'b1;
          S11            = 1'b1;
          S10            = 1'b1;
          flush_cnt_next = 3'd0;
          state_next     = FLUSH;
        end else if (br_req && br_taken) begin
          L_PC           = 1'b1;
          S10            = 1'b1;
          flush_cnt_next = 3'd0;
          state_next     = FLUSH;
        end else begin
          I_PC = !stall_in;
        end
      end

      WAIT_DM: begin
        // The DM source stays selected while waiting so the PC mux is
        // already pointing at the bus when the data arrives.
        dm_rd_en = 1'b1;
        S11      = 1'b1;
        if (dm_valid) begin
          L_PC           = 1'b1;
          flush_cnt_next = 3'd0;
          state_next     = FLUSH;
        end else begin
          tmo_cnt_next = sat_inc8(tmo_cnt);
          if (tmo_cnt_next == TMO_LEN) begin
            state_next = FAULT;
          end
        end
      end

      FLUSH: begin
        // Redirect requests are squashed along with the wrong-path
        // instructions; only a stall can still hold the PC.
        flush          = 1'b1;
        I_PC           = !stall_in;
        flush_cnt_next = sat_inc3(flush_cnt);
        if (flush_cnt_next == FLUSH_LEN) begin
          state_next = RUN;
        end
      end

      HALT: begin
        halted = 1'b1;
      end

      FAULT: begin
        fault = 1'b1;
      end

      default: begin
        state_next = RESET_HOLD;
      end
    endcase
  end

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  localparam int FC  = 2;
  localparam int TMO = 15;

  logic CLK = 1'b0;
  logic RST_N = 1'b1;
  logic stall_in = 1'b0, br_req = 1'b0, br_taken = 1'b0, jr_req = 1'b0;
  logic ret_req = 1'b0, dm_valid = 1'b0, halt_in = 1'b0;
  logic I_PC, L_PC, S11, S10, dm_rd_en, flush, halted, fault;

  logic [7:0] or2 = 8'h00;
  logic [7:0] dm  = 8'h00;
  logic [7:0] r0  = 8'h00;
  logic [7:0] pc  = 8'h00;

  int n_tests = 0;
  int n_fail  = 0;

  pc_sequencer #(.FLUSH_CYCLES(FC), .DM_TIMEOUT(TMO)) dut (
    .CLK(CLK), .RST_N(RST_N), .stall_in(stall_in), .br_req(br_req),
    .br_taken(br_taken), .jr_req(jr_req), .ret_req(ret_req),
    .dm_valid(dm_valid), .halt_in(halt_in), .I_PC(I_PC), .L_PC(L_PC),
    .S11(S11), .S10(S10), .dm_rd_en(dm_rd_en), .flush(flush),
    .halted(halted), .fault(fault)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // The PC register the sequencer steers.
  always @(posedge CLK) begin
    if (!RST_N) pc <= 8'h00;
    else if (L_PC) begin
      case ({S11, S10})
        2'b11:   pc <= r0;
        2'b10:   pc <= dm;
        2'b01:   pc <= or2;
        default: pc <= pc;
      endcase
    end else if (I_PC) pc <= pc + 8'h01;
  end

  // Behavioural reference: what mode the sequencer is in, how many wait
  // cycles have elapsed and how many flush cycles remain.
  bit m_known = 0, m_hold = 0, m_halt = 0, m_fault = 0, m_wait = 0;
  int m_wait_cnt = 0, m_flush_left = 0;

  always @(negedge CLK) begin : model_cmp
    logic ei, el, erd, efl, eht, eft;
    logic [1:0] es;
    ei = 0; el = 0; erd = 0; efl = 0; eht = 0; eft = 0; es = 2'b00;
    if (m_known) begin
      if (m_hold) begin
      end else if (m_halt) eht = 1;
      else if (m_fault) eft = 1;
      else if (m_wait) begin
        erd = 1; es = 2'b10; el = dm_valid;
      end else if (m_flush_left > 0) begin
        efl = 1; ei = !stall_in;
      end else if (halt_in) begin
      end else if (ret_req) begin
        erd = 1; es = 2'b10; el = dm_valid;
      end else if (jr_req) begin
        el = 1; es = 2'b11;
      end else if (br_req && br_taken) begin
        el = 1; es = 2'b01;
      end else ei = !stall_in;
      check("outputs{I,L,S11,S10,rd,fl,ht,ft}",
            {I_PC, L_PC, S11, S10, dm_rd_en, flush, halted, fault},
            {ei, el, es, erd, efl, eht, eft});
    end
    if (!RST_N) begin
      m_known = 1; m_hold = 1; m_halt = 0; m_fault = 0; m_wait = 0;
      m_wait_cnt = 0; m_flush_left = 0;
    end else if (m_known) begin
      if (m_hold) m_hold = 0;
      else if (m_halt || m_fault) begin
      end else if (m_wait) begin
        if (dm_valid) begin
          m_wait = 0; m_flush_left = FC;
        end else begin
          m_wait_cnt++;
          if (m_wait_cnt >= TMO) begin m_wait = 0; m_fault = 1; end
        end
      end else if (m_flush_left > 0) m_flush_left--;
      else if (halt_in) m_halt = 1;
      else if (el) m_flush_left = FC;
      else if (ret_req) begin m_wait = 1; m_wait_cnt = 0; end
    end
  end

  task automatic set_in(input logic h, r, j, b, t, s, d);
    halt_in = h; ret_req = r; jr_req = j; br_req = b; br_taken = t;
    stall_in = s; dm_valid = d;
  endtask

  // One cycle: inputs change just after the rising edge, checks at the
  // falling edge see this cycle's outputs and the PC value during it.
  task automatic cycle(input logic h, r, j, b, t, s, d);
    @(posedge CLK); #1;
    set_in(h, r, j, b, t, s, d);
    @(negedge CLK);
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, 0, 0);
  endtask

  // Leaves the bench at the falling edge of the RESET_HOLD cycle.
  task automatic do_reset();
    @(posedge CLK); #1;
    RST_N = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0);
    @(posedge CLK); #1;
    RST_N = 1'b1;
    @(negedge CLK);
    check("reset_hold_outputs",
          {I_PC, L_PC, S11, S10, dm_rd_en, flush, halted, fault}, 8'h00);
    check("reset_hold_pc", pc, 8'h00);
  endtask

  initial begin
    // 1: reset release, idle -> increment every cycle
    do_reset();
    for (int k = 0; k < 5; k++) begin
      idle();
      check("t1_inc", 8'(I_PC), 8'h01);
      check("t1_pc", pc, 8'(k));
    end
    idle();
    check("t1_pc_final", pc, 8'h05);

    // 2: taken branch at PC=03 to OR2=40
    do_reset();
    idle(); idle(); idle();
    or2 = 8'h40;
    cycle(0, 0, 0, 1, 1, 0, 0);
    check("t2_pc_before", pc, 8'h03);
    check("t2_load", {6'b0, L_PC, I_PC}, 8'h02);
    check("t2_sel", {6'b0, S11, S10}, 8'h01);
    idle();
    check("t2_pc_target", pc, 8'h40);
    check("t2_flush1", 8'(flush), 8'h01);
    idle();
    check("t2_flush2", 8'(flush), 8'h01);
    check("t2_pc_41", pc, 8'h41);
    idle();
    check("t2_flush_end", 8'(flush), 8'h00);
    check("t2_pc_42", pc, 8'h42);

    // 3: return with dm_valid three cycles after the request, DM=22
    do_reset();
    idle();
    dm = 8'h22;
    cycle(0, 1, 0, 0, 0, 0, 0);
    check("t3_rd0", {dm_rd_en, L_PC, I_PC, S11, S10}, 8'h12);
    for (int k = 0; k < 2; k++) begin
      idle();
      check("t3_rd_wait", {dm_rd_en, L_PC, I_PC, S11, S10}, 8'h12);
      check("t3_pc_hold", pc, 8'h01);
    end
    cycle(0, 0, 0, 0, 0, 0, 1);
    check("t3_rd_load", {dm_rd_en, L_PC, I_PC, S11, S10}, 8'h1A);
    check("t3_pc_hold2", pc, 8'h01);
    idle();
    check("t3_pc_target", pc, 8'h22);
    check("t3_flush1", {flush, dm_rd_en}, 8'h02);
    idle();
    check("t3_flush2", 8'(flush), 8'h01);
    idle();
    check("t3_flush_end", 8'(flush), 8'h00);
    check("t3_pc_24", pc, 8'h24);

    // 4: return whose data never arrives -> FAULT after 15 wait cycles
    do_reset();
    cycle(0, 1, 0, 0, 0, 0, 0);
    check("t4_rd0", 8'(dm_rd_en), 8'h01);
    for (int k = 0; k < TMO; k++) begin
      idle();
      check("t4_waiting", {dm_rd_en, fault}, 8'h02);
    end
    idle();
    check("t4_fault", {fault, dm_rd_en, I_PC, L_PC}, 8'h08);
    check("t4_pc_frozen", pc, 8'h00);
    cycle(0, 1, 1, 1, 1, 0, 1);
    check("t4_fault_sticky", {fault, I_PC, L_PC}, 8'h04);
    idle();
    check("t4_pc_frozen2", pc, 8'h00);

    // 5: halt and indirect jump together -> halt wins
    do_reset();
    check("t5_fault_cleared", 8'(fault), 8'h00);
    idle();
    r0 = 8'h77;
    cycle(1, 0, 1, 0, 0, 0, 0);
    check("t5_no_action", {I_PC, L_PC, S11, S10}, 8'h00);
    idle();
    check("t5_halted", {halted, I_PC, L_PC}, 8'h04);
    check("t5_pc_same", pc, 8'h01);
    cycle(0, 0, 1, 0, 0, 0, 0);
    check("t5_still_halted", 8'(halted), 8'h01);
    check("t5_pc_same2", pc, 8'h01);
    do_reset();

    // 6: stall with an untaken branch holds PC for two cycles
    idle();
    or2 = 8'h99;
    cycle(0, 0, 0, 1, 0, 1, 0);
    check("t6_hold1", {I_PC, L_PC}, 8'h00);
    cycle(0, 0, 0, 1, 0, 1, 0);
    check("t6_hold2", pc, 8'h01);
    idle();
    check("t6_resume", 8'(I_PC), 8'h01);
    check("t6_pc_1", pc, 8'h01);
    idle();
    check("t6_pc_2", pc, 8'h02);

    // 7: ret with immediate data, stall in flush, PC wrap, resets mid-wait/flush
    dm = 8'h5A;
    cycle(0, 1, 0, 0, 0, 0, 1);
    check("t7_ret_now", {dm_rd_en, L_PC, S11, S10}, 8'h0E);
    idle();
    check("t7_pc_5a", pc, 8'h5A);
    idle(); idle();
    cycle(0, 1, 0, 0, 0, 0, 0);
    idle();
    check("t7_mid_wait", 8'(dm_rd_en), 8'h01);
    do_reset();
    r0 = 8'hFF;
    cycle(0, 0, 1, 0, 0, 0, 0);
    check("t7_jr_sel", {L_PC, S11, S10}, 8'h07);
    cycle(0, 0, 0, 0, 0, 1, 0);
    check("t7_flush_stall", {flush, I_PC}, 8'h02);
    check("t7_pc_ff", pc, 8'hFF);
    idle();
    check("t7_flush_inc", {flush, I_PC}, 8'h03);
    idle();
    check("t7_pc_wrap", pc, 8'h00);
    check("t7_run", {flush, I_PC}, 8'h01);
    r0 = 8'h10;
    cycle(0, 0, 1, 0, 0, 0, 0);
    idle();
    check("t7_mid_flush", 8'(flush), 8'h01);
    do_reset();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
